// File: rtl/msk_g4_encoder.sv
// msk_g4_encoder: masks GF(4) operand pairs into d-share Boolean sharings, b one cycle ahead of a.
// Ports: clk/nrst (sync active-low), in_valid/in_ready/in_a/in_b operand handshake,
// rnd/rnd_valid/rnd_ready randomness handshake, out_b*/out_b_valid then out_a*/out_a_valid.
// Build option: MSK_ENC_CLEAR_EN zeroes each output sharing whenever its valid flag is low.
module msk_g4_encoder #(
  parameter int d = 2,
  localparam int RND_W = 4*(d-1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  input  logic [RND_W-1:0] rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [d-1:0]     out_a0,
  output logic [d-1:0]     out_a1,
  output logic [d-1:0]     out_b0,
  output logic [d-1:0]     out_b1,
  output logic             out_a_valid,
  output logic             out_b_valid
);
  typedef enum logic [1:0] {IDLE, B_OUT, A_OUT} state_t;
  state_t state, state_nx;
  logic acc, ld_a;
  logic [d-1:0] nb0, nb1, na0, na1, hold_a0, hold_a1;
  // Upper shares are the raw slice; share 0 absorbs the bit and the slice parity.
  function automatic logic [d-1:0] enc(input logic x, input logic [d-2:0] r);
    return {r, x ^ (^r)};
  endfunction
  assign nb0 = enc(in_b[0], rnd[0*(d-1) +: d-1]);
  assign nb1 = enc(in_b[1], rnd[1*(d-1) +: d-1]);
  assign na0 = enc(in_a[0], rnd[2*(d-1) +: d-1]);
  assign na1 = enc(in_a[1], rnd[3*(d-1) +: d-1]);
  assign ld_a = state == B_OUT;
  always_ff @(posedge clk)
    if (!nrst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    if (state == B_OUT) state_nx = A_OUT;
    else if (acc) state_nx = B_OUT;
  end
  always_comb begin
    in_ready = nrst & (state == IDLE | state == A_OUT);
    acc = in_valid & rnd_valid & in_ready;
    rnd_ready = acc;
    out_b_valid = state == B_OUT;
    out_a_valid = state == A_OUT;
  end
  always_ff @(posedge clk)
    if (!nrst) begin
      {hold_a0, hold_a1, out_a0, out_a1, out_b0, out_b1} <= '0;
    end else begin
      if (acc) {hold_a0, hold_a1} <= {na0, na1};
`ifdef MSK_ENC_CLEAR_EN
      {out_b0, out_b1} <= acc ? {nb0, nb1} : '0;
      {out_a0, out_a1} <= ld_a ? {hold_a0, hold_a1} : '0;
`else
      if (acc) {out_b0, out_b1} <= {nb0, nb1};
      if (ld_a) {out_a0, out_a1} <= {hold_a0, hold_a1};
`endif
    end
endmodule

// File: tb/tb_msk_g4_encoder.sv
// tb_msk_g4_encoder: directed checks of msk_g4_encoder at d=2 and d=3 sharing one control stream.
module tb_msk_g4_encoder;
  logic clk = 0, nrst = 0, in_valid = 0, rnd_valid = 0;
  logic [1:0] in_a = 0, in_b = 0;
  logic [3:0] rnd2 = 0;
  logic [7:0] rnd3 = 0;
  logic ir2, rr2, av2, bv2, ir3, rr3, av3, bv3;
  logic [1:0] a0_2, a1_2, b0_2, b1_2;
  logic [2:0] a0_3, a1_3, b0_3, b1_3;
  logic [1:0] la, lb;
  logic [7:0] lr;
  int n_cmp = 0, n_err = 0, n_acc = 0;
  always #5 clk = ~clk;
  msk_g4_encoder #(.d(2)) u2 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(ir2), .in_a(in_a), .in_b(in_b),
    .rnd(rnd2), .rnd_valid(rnd_valid), .rnd_ready(rr2), .out_a0(a0_2), .out_a1(a1_2),
    .out_b0(b0_2), .out_b1(b1_2), .out_a_valid(av2), .out_b_valid(bv2)
  );
  msk_g4_encoder #(.d(3)) u3 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(ir3), .in_a(in_a), .in_b(in_b),
    .rnd(rnd3), .rnd_valid(rnd_valid), .rnd_ready(rr3), .out_a0(a0_3), .out_a1(a1_3),
    .out_b0(b0_3), .out_b1(b1_3), .out_a_valid(av3), .out_b_valid(bv3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] all_out;
    return {8'h0, a0_2, a1_2, b0_2, b1_2, a0_3, a1_3, b0_3, b1_3, av2, bv2, av3, bv3};
  endfunction
  initial begin
    in_valid = 1; rnd_valid = 1; in_a = 2'b11; in_b = 2'b11; rnd2 = 4'hf; rnd3 = 8'hff;
    for (int i = 0; i < 2; i++) begin
      tick;
      check("rst_out", all_out(), 0);
      check("rst_ready", {ir2, rr2, ir3, rr3}, 0);
    end
    nrst = 1; in_valid = 0;
    #1 check("rel_in_ready", {ir2, ir3}, 2'b11);
    in_valid = 1; in_a = 2'b10; in_b = 2'b01; rnd2 = 4'b1011;
    #1 check("basic_rnd_ready", rr2, 1);
    tick;
    in_valid = 0;
    check("basic_b", {bv2, av2, ir2, b0_2, b1_2}, {3'b100, 2'b10, 2'b11});
    tick;
    check("basic_a", {av2, bv2, ir2, a0_2, a1_2}, {3'b101, 2'b00, 2'b10});
`ifdef MSK_ENC_CLEAR_EN
    check("clr_b_in_a_out", {b0_2, b1_2}, 0);
`else
    check("hold_b_in_a_out", {b0_2, b1_2}, {2'b10, 2'b11});
`endif
    tick;
    check("idle_valid", {av2, bv2, ir2}, 3'b001);
`ifdef MSK_ENC_CLEAR_EN
    check("clr_idle", {a0_2, a1_2, b0_2, b1_2}, 0);
`else
    check("hold_idle", {a0_2, a1_2, b0_2, b1_2}, {2'b00, 2'b10, 2'b10, 2'b11});
`endif
    in_valid = 1; rnd_valid = 0; in_a = 2'b01; in_b = 2'b10; rnd2 = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_ready", {rr2, ir2}, 2'b01);
      tick;
      check("stall_no_valid", {av2, bv2}, 0);
    end
    rnd_valid = 1;
    #1 check("stall_acc", rr2, 1);
    tick;
    in_valid = 0;
    check("stall_b", {bv2, b0_2, b1_2}, {1'b1, 2'b00, 2'b10});
    tick;
    check("stall_a", {av2, a0_2, a1_2}, {1'b1, 2'b10, 2'b00});
    tick;
    in_valid = 1; rnd_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_a = 2'($urandom); in_b = 2'($urandom); rnd3 = 8'($urandom);
      #1;
      if (rr3) begin
        n_acc++; la = in_a; lb = in_b; lr = rnd3;
      end
      tick;
      check("b2b_alt", {bv3, av3}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i % 2 == 0) begin
        check("b2b_b_xor", {^b0_3, ^b1_3}, {lb[1], lb[0]} & 2'b11 ? {lb[0], lb[1]} : 2'b00);
        check("b2b_b_rnd", {b0_3[2:1], b1_3[2:1]}, {lr[1:0], lr[3:2]});
      end else begin
        check("b2b_a_xor", {^a1_3, ^a0_3}, la);
        check("b2b_a_rnd", {a0_3[2:1], a1_3[2:1]}, {lr[5:4], lr[7:6]});
      end
    end
    in_valid = 0;
    tick;
    check("b2b_acc_count", n_acc, 5);
    in_valid = 1; in_a = 2'b11; in_b = 2'b11; rnd2 = 4'b0101;
    tick;
    in_valid = 0;
    check("mid_b_valid", bv2, 1);
    nrst = 0;
    tick;
    nrst = 1;
    check("mid_rst_out", all_out(), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mid_no_a", {av2, av3, bv2, bv3}, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
